bridge_req_arbiter: RTL and testbench
=====================================

// Module: bridge_req_arbiter
//
// PURPOSE
// - N-channel arbiter for core-to-target bridge requests: NUM_CH core-side request channels share one bridge_driver request port.
// - Successor to the fixed 7-command request block: channel count, param width and arbitration mode are parametrised.
// - Grants, params and results are registered, so a channel may change its inputs after grant without corrupting the in-flight request.
// - Sits between core logic (ready_to_run, dataslot read/write/flush, ...) and the bridge request driver.
//
// PARAMETERS
// - NUM_CH          7    number of request channels, 2..16; channel 0 is highest priority in fixed mode
// - WORD_W          32   width of command word and result
// - PARAM_W         256  width of the expanded command parameter block
// - ROUND_ROBIN     0    0 = fixed priority (lowest index wins), 1 = round-robin starting after last grant
// - TIMEOUT_CYCLES  4096 cycles in ACTIVE before abort; used only when BRIDGE_REQ_TIMEOUT_EN is defined
//
// PORTS
// - clk         in   1                 bridge clock; all logic on posedge
// - reset       in   1                 synchronous, active-high
// - ch_valid    in   NUM_CH            per-channel request; held until its ch_done
// - ch_word     in   NUM_CH*WORD_W     per-channel command word, channel i at [i*WORD_W +: WORD_W]
// - ch_param    in   NUM_CH*PARAM_W    per-channel param block, channel i at [i*PARAM_W +: PARAM_W]
// - ch_done     out  NUM_CH            one-cycle completion pulse to the granted channel
// - ch_result   out  WORD_W            result of the completed request; valid when any ch_done bit is high
// - ch_timeout  out  1                 high with ch_done when the request was aborted (macro only; else tied 0)
// - grant_id    out  $clog2(NUM_CH)    index of the current/last granted channel
// - busy        out  1                 high in ACTIVE and DONE
// - req_valid   out  1                 request to bridge driver
// - req_word    out  WORD_W            registered command word
// - req_param   out  PARAM_W           registered param block
// - req_done    in   1                 driver: request read and response written
// - req_result  in   WORD_W            driver response; sampled when req_done is high
//
// BEHAVIOUR
// - Reset: state IDLE; req_valid=0, req_word=0, req_param=0, ch_done=0, ch_result=0, ch_timeout=0, busy=0, grant_id=0; RR pointer = NUM_CH-1 (ch0 wins first).
// - Interface: one clock; reset is synchronous and active-high.
// - States: IDLE -> ACTIVE -> DONE -> IDLE.
// - IDLE: if any ch_valid, select winner; at the edge register grant_id, req_word, req_param; go ACTIVE. Latency ch_valid -> req_valid = 1 cycle.
// - ACTIVE: req_valid=1, word/param held constant. On req_done: latch req_result into ch_result, go DONE.
// - DONE (exactly one cycle): ch_done[grant_id]=1, all other ch_done bits 0; busy=1. Next state IDLE; the channel drops ch_valid after this edge, so no double grant.
// - Fixed mode: lowest set index of ch_valid wins. RR mode: first set index scanning ptr+1 .. ptr+NUM_CH (mod NUM_CH); ptr <= winner at grant.
// - Arbitration evaluated only in IDLE; minimum spacing between grants = 3 cycles.
// - ch_valid of the granted channel deasserting during ACTIVE: ignored, request completes normally.
// - req_done while IDLE or DONE: ignored.
// - ch_result holds its value until the next completion; unused param bits are zero, not X.
// - Reset mid-ACTIVE: back to IDLE next edge, req_valid drops, no ch_done pulse is issued.
//
// CONFIGURATION
// - Macro BRIDGE_REQ_TIMEOUT_EN defined: 16-bit counter cleared on entering ACTIVE, increments each ACTIVE cycle;
//   on reaching TIMEOUT_CYCLES without req_done -> DONE with ch_result = all-ones and ch_timeout=1.
//   req_done in the same cycle as expiry: normal completion wins (ch_timeout=0).
// - Macro undefined: no counter; ACTIVE waits indefinitely; ch_timeout tied 0.
//
// TESTING
// - Reset, then ch_valid[3]=1, ch_word[3]=32'h0000_0140 -> req_valid next cycle, req_word=32'h0000_0140, grant_id=3.
// - ACTIVE, req_done=1 with req_result=32'h0000_0002 -> next cycle ch_done=7'b0001000, ch_result=32'h2, then IDLE.
// - Fixed mode, ch_valid=7'b0010110 held -> grants in order 1, 2, 4, each channel dropping valid after its done.
// - ROUND_ROBIN=1, ch_valid=7'b0000011 continuously reasserted -> grants alternate 0,1,0,1.
// - Change ch_param[1] during ACTIVE for ch1 -> req_param unchanged; reset asserted mid-ACTIVE -> req_valid=0, no ch_done.
// - BRIDGE_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, no req_done -> ch_done plus ch_timeout=1, ch_result=32'hFFFF_FFFF after 8 ACTIVE cycles.

Source files
------------

// File: rtl/bridge_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : bridge_req_arbiter
// Purpose  : NUM_CH-channel arbiter feeding one bridge_driver request port;
//            fixed or round-robin, optional abort via BRIDGE_REQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module bridge_req_arbiter #(
  parameter int NUM_CH         = 7,
  parameter int WORD_W         = 32,
  parameter int PARAM_W        = 256,
  parameter int ROUND_ROBIN    = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_valid,
  input  logic [NUM_CH*WORD_W-1:0]    ch_word,
  input  logic [NUM_CH*PARAM_W-1:0]   ch_param,
  output logic [NUM_CH-1:0]           ch_done,
  output logic [WORD_W-1:0]           ch_result,
  output logic                        ch_timeout,
  output logic [$clog2(NUM_CH)-1:0]   grant_id,
  output logic                        busy,
  output logic                        req_valid,
  output logic [WORD_W-1:0]           req_word,
  output logic [PARAM_W-1:0]          req_param,
  input  logic                        req_done,
  input  logic [WORD_W-1:0]           req_result
);

  localparam int         c_ID_W   = $clog2(NUM_CH);
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACTIVE = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;

  generate
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
      $error("bridge_req_arbiter: NUM_CH must be 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
      $error("bridge_req_arbiter: TIMEOUT_CYCLES must fit the 16-bit counter");
    end
  endgenerate

  logic [1:0]          r_state;
  logic [c_ID_W-1:0]   r_grant;
  logic [WORD_W-1:0]   r_word;
  logic [PARAM_W-1:0]  r_param;
  logic [WORD_W-1:0]   r_result;

  logic                w_any;
  logic [c_ID_W-1:0]   w_start;
  logic [c_ID_W-1:0]   w_off;
  logic [c_ID_W-1:0]   w_win;
  logic [c_ID_W:0]     w_sum;
  logic [NUM_CH-1:0]   w_rot;
  logic [WORD_W-1:0]   w_sel_word;
  logic [PARAM_W-1:0]  w_sel_param;

  assign w_any = |ch_valid;

  generate
    if (ROUND_ROBIN != 0) begin : g_rr
      logic [c_ID_W-1:0] r_ptr;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_ptr <= c_ID_W'(NUM_CH - 1);
        end else if (r_state == c_IDLE && w_any) begin
          r_ptr <= w_win;
        end
      end

      assign w_start = (r_ptr == c_ID_W'(NUM_CH - 1)) ? '0 : r_ptr + 1'b1;
    end else begin : g_fixed
      assign w_start = '0;
    end
  endgenerate

  // Rotate the request vector so the scan start sits at bit 0, pick the
  // lowest set bit, then map the offset back to a channel index.
  always_comb begin
    w_rot = NUM_CH'({ch_valid, ch_valid} >> w_start);
    w_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = c_ID_W'(i);
    end
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= (c_ID_W + 1)'(NUM_CH)) w_sum = w_sum - (c_ID_W + 1)'(NUM_CH);
    w_win = w_sum[c_ID_W-1:0];
  end

  always_comb begin
    w_sel_word  = '0;
    w_sel_param = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_win == c_ID_W'(i)) begin
        w_sel_word  = ch_word[i*WORD_W +: WORD_W];
        w_sel_param = ch_param[i*PARAM_W +: PARAM_W];
      end
    end
  end

`ifdef BRIDGE_REQ_TIMEOUT_EN
  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt;
  logic        r_timeout;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_grant  <= '0;
      r_word   <= '0;
      r_param  <= '0;
      r_result <= '0;
`ifdef BRIDGE_REQ_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_word  <= w_sel_word;
            r_param <= w_sel_param;
            r_state <= c_ACTIVE;
`ifdef BRIDGE_REQ_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        c_ACTIVE: begin
          // A response arriving on the expiry cycle still counts as success.
          if (req_done) begin
            r_result <= req_result;
            r_state  <= c_DONE;
`ifdef BRIDGE_REQ_TIMEOUT_EN
            r_timeout <= 1'b0;
          end else if (r_cnt == c_TMO_LAST) begin
            r_result  <= '1;
            r_timeout <= 1'b1;
            r_state   <= c_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
`endif
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_comb begin
    ch_done = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_state == c_DONE && r_grant == c_ID_W'(i)) ch_done[i] = 1'b1;
    end
  end

`ifdef BRIDGE_REQ_TIMEOUT_EN
  assign ch_timeout = (r_state == c_DONE) && r_timeout;
`else
  assign ch_timeout = 1'b0;
`endif

  assign ch_result = r_result;
  assign grant_id  = r_grant;
  assign busy      = (r_state != c_IDLE);
  assign req_valid = (r_state == c_ACTIVE);
  assign req_word  = r_word;
  assign req_param = r_param;

endmodule
`default_nettype wire

// File: tb/tb_bridge_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_bridge_req_arbiter
// Purpose  : vector table, corner sequences and random traffic against a
//            fixed-priority and a round-robin instance of bridge_req_arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_bridge_req_arbiter;

  localparam int c_N  = 7;
  localparam int c_W  = 32;
  localparam int c_PW = 256;

  logic clk;
  logic reset;

  // index 0: fixed priority, index 1: round robin
  logic [c_N-1:0]      valid  [2];
  logic [c_N*c_W-1:0]  word   [2];
  logic [c_N*c_PW-1:0] param  [2];
  logic [c_N-1:0]      done   [2];
  logic [c_W-1:0]      result [2];
  logic                tmo    [2];
  logic [2:0]          gid    [2];
  logic                bsy    [2];
  logic                rv     [2];
  logic [c_W-1:0]      rword  [2];
  logic [c_PW-1:0]     rparam [2];
  logic                rdone  [2];
  logic [c_W-1:0]      rres   [2];

  bridge_req_arbiter #(.NUM_CH(c_N), .WORD_W(c_W), .PARAM_W(c_PW),
                       .ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) u_fix (
    .clk(clk), .reset(reset), .ch_valid(valid[0]), .ch_word(word[0]),
    .ch_param(param[0]), .ch_done(done[0]), .ch_result(result[0]),
    .ch_timeout(tmo[0]), .grant_id(gid[0]), .busy(bsy[0]),
    .req_valid(rv[0]), .req_word(rword[0]), .req_param(rparam[0]),
    .req_done(rdone[0]), .req_result(rres[0]));

  bridge_req_arbiter #(.NUM_CH(c_N), .WORD_W(c_W), .PARAM_W(c_PW),
                       .ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) u_rr (
    .clk(clk), .reset(reset), .ch_valid(valid[1]), .ch_word(word[1]),
    .ch_param(param[1]), .ch_done(done[1]), .ch_result(result[1]),
    .ch_timeout(tmo[1]), .grant_id(gid[1]), .busy(bsy[1]),
    .req_valid(rv[1]), .req_word(rword[1]), .req_param(rparam[1]),
    .req_done(rdone[1]), .req_result(rres[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int             m;
    logic [c_N-1:0] mask;
    logic [c_W-1:0] res;
    int             expg;
  } vec_t;
  vec_t tbl [16];

  logic [c_W-1:0]  mw [c_N];
  logic [c_PW-1:0] mp [c_N];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [c_W-1:0] wexp(input int ch);
    return 32'h0000_0080 + 32'(ch) * 32'h40;
  endfunction

  function automatic logic [c_PW-1:0] pexp(input int ch);
    return {8{32'hC0DE_0000 | 32'(ch)}};
  endfunction

  function automatic logic [c_PW-1:0] rnd256();
    logic [c_PW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference arbitration straight from the selection rules.
  function automatic int arb(input int m, input logic [c_N-1:0] req, input int last);
    if (m == 0) begin
      for (int i = 0; i < c_N; i++) if (req[i]) return i;
    end else begin
      for (int k = 1; k <= c_N; k++) if (req[(last + k) % c_N]) return (last + k) % c_N;
    end
    return -1;
  endfunction

  task automatic preload();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < c_N; i++) begin
        word[m][i*c_W +: c_W]   = wexp(i);
        param[m][i*c_PW +: c_PW] = pexp(i);
      end
  endtask

  task automatic run_txn(input int m, input logic [c_N-1:0] mask,
                         input logic [c_W-1:0] res, input int expg);
    valid[m] = mask;
    step();
    chk("grant_req_valid", rv[m], 1);
    chk("grant_id", gid[m], expg);
    chk("grant_req_word", rword[m], wexp(expg));
    chk("grant_req_param", rparam[m], pexp(expg));
    rdone[m] = 1'b1;
    rres[m]  = res;
    step();
    rdone[m] = 1'b0;
    valid[m] = '0;
    chk("done_onehot", done[m], 7'b1 << expg);
    chk("done_result", result[m], res);
    chk("done_timeout", tmo[m], 0);
    chk("done_req_valid", rv[m], 0);
    step();
    chk("idle_busy", bsy[m], 0);
    chk("idle_done", done[m], 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    for (int m = 0; m < 2; m++) begin
      chk("rst_req_valid", rv[m], 0);
      chk("rst_req_word", rword[m], 0);
      chk("rst_req_param", rparam[m], 0);
      chk("rst_done", done[m], 0);
      chk("rst_result", result[m], 0);
      chk("rst_timeout", tmo[m], 0);
      chk("rst_busy", bsy[m], 0);
      chk("rst_grant_id", gid[m], 0);
    end
    reset = 1'b0;
  endtask

  task automatic run_random(input int m, input int iters);
    int last = c_N - 1;
    logic [c_N-1:0] pend = '0;
    logic [c_W-1:0] last_res = '0;
    int win, n;
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < c_N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          mw[i] = $urandom;
          mp[i] = rnd256();
          word[m][i*c_W +: c_W]    = mw[i];
          param[m][i*c_PW +: c_PW] = mp[i];
        end
      end
      valid[m] = pend;
      rdone[m] = ($urandom_range(0, 3) == 0);
      rres[m]  = $urandom;
      step();
      rdone[m] = 1'b0;
      if (pend == '0) begin
        chk("rnd_idle_busy", bsy[m], 0);
        chk("rnd_idle_done", done[m], 0);
        chk("rnd_idle_result", result[m], last_res);
        continue;
      end
      win  = arb(m, pend, last);
      last = win;
      chk("rnd_req_valid", rv[m], 1);
      chk("rnd_grant_id", gid[m], win);
      chk("rnd_req_word", rword[m], mw[win]);
      chk("rnd_req_param", rparam[m], mp[win]);
      word[m][win*c_W +: c_W]    = $urandom;
      param[m][win*c_PW +: c_PW] = rnd256();
      if ($urandom_range(0, 3) == 0) begin
        pend[win] = 1'b0;
        valid[m]  = pend;
      end
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        step();
        chk("rnd_active_valid", rv[m], 1);
        chk("rnd_active_word", rword[m], mw[win]);
        chk("rnd_active_param", rparam[m], mp[win]);
        chk("rnd_active_done", done[m], 0);
      end
      rdone[m] = 1'b1;
      rres[m]  = $urandom;
      last_res = rres[m];
      step();
      rdone[m] = 1'b0;
      chk("rnd_done_onehot", done[m], 7'b1 << win);
      chk("rnd_done_result", result[m], last_res);
      chk("rnd_done_timeout", tmo[m], 0);
      chk("rnd_done_busy", bsy[m], 1);
      pend[win] = 1'b0;
      valid[m]  = pend;
      step();
      chk("rnd_after_busy", bsy[m], 0);
      chk("rnd_after_done", done[m], 0);
    end
    valid[m] = '0;
    step();
  endtask

  initial begin
    tbl[0]  = '{0, 7'b0001000, 32'h0000_0002, 3};
    tbl[1]  = '{0, 7'b1000000, 32'hA000_0001, 6};
    tbl[2]  = '{0, 7'b1111111, 32'hA000_0002, 0};
    tbl[3]  = '{0, 7'b1100000, 32'hA000_0003, 5};
    tbl[4]  = '{0, 7'b0010110, 32'hA000_0004, 1};
    tbl[5]  = '{0, 7'b0000110, 32'hA000_0005, 1};
    tbl[6]  = '{1, 7'b0000011, 32'hB000_0000, 0};
    tbl[7]  = '{1, 7'b0000011, 32'hB000_0001, 1};
    tbl[8]  = '{1, 7'b0000011, 32'hB000_0002, 0};
    tbl[9]  = '{1, 7'b0000011, 32'hB000_0003, 1};
    tbl[10] = '{1, 7'b1000001, 32'hB000_0004, 6};
    tbl[11] = '{1, 7'b1000001, 32'hB000_0005, 0};
    tbl[12] = '{1, 7'b0010100, 32'hB000_0006, 2};
    tbl[13] = '{1, 7'b0010100, 32'hB000_0007, 4};
    tbl[14] = '{1, 7'b0010001, 32'hB000_0008, 0};
    tbl[15] = '{1, 7'b1111111, 32'hB000_0009, 1};

    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      valid[m] = '0;
      word[m]  = '0;
      param[m] = '0;
      rdone[m] = 1'b0;
      rres[m]  = '0;
    end
    do_reset();
    preload();

    for (int v = 0; v < 16; v++) run_txn(tbl[v].m, tbl[v].mask, tbl[v].res, tbl[v].expg);

    // Requests held together: served lowest-first, each dropping after done.
    begin
      logic [c_N-1:0] hold = 7'b0010110;
      int order [3] = '{1, 2, 4};
      valid[0] = hold;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("held_grant", gid[0], order[k]);
        chk("held_req_valid", rv[0], 1);
        rdone[0] = 1'b1;
        rres[0]  = 32'(k);
        step();
        rdone[0] = 1'b0;
        chk("held_done", done[0], 7'b1 << order[k]);
        hold[order[k]] = 1'b0;
        valid[0] = hold;
        step();
      end
      chk("held_idle_busy", bsy[0], 0);
    end

    // Inputs of the granted channel change while it is in flight.
    valid[0] = 7'b0000010;
    step();
    chk("hold_param_grant", rparam[0], pexp(1));
    param[0][c_PW +: c_PW] = ~pexp(1);
    word[0][c_W +: c_W]    = ~wexp(1);
    valid[0] = '0;
    step();
    step();
    chk("hold_param_active", rparam[0], pexp(1));
    chk("hold_word_active", rword[0], wexp(1));
    chk("hold_valid_active", rv[0], 1);
    rdone[0] = 1'b1;
    rres[0]  = 32'h5A5A_0001;
    step();
    rdone[0] = 1'b0;
    chk("hold_done", done[0], 7'b0000010);
    chk("hold_result", result[0], 32'h5A5A_0001);
    preload();
    step();

    // Reset while a request is outstanding.
    valid[0] = 7'b0000100;
    step();
    chk("midrst_active", rv[0], 1);
    reset = 1'b1;
    step();
    chk("midrst_req_valid", rv[0], 0);
    chk("midrst_done", done[0], 0);
    chk("midrst_busy", bsy[0], 0);
    reset    = 1'b0;
    valid[0] = '0;
    step();
    chk("midrst_no_done", done[0], 0);
    chk("midrst_idle", bsy[0], 0);

`ifdef BRIDGE_REQ_TIMEOUT_EN
    valid[0] = 7'b0000100;
    step();
    for (int k = 0; k < 7; k++) begin
      chk("tmo_waiting", rv[0], 1);
      step();
    end
    chk("tmo_last_active", rv[0], 1);
    step();
    valid[0] = '0;
    chk("tmo_done", done[0], 7'b0000100);
    chk("tmo_flag", tmo[0], 1);
    chk("tmo_result", result[0], 32'hFFFF_FFFF);
    step();
    valid[0] = 7'b0000100;
    step();
    for (int k = 0; k < 7; k++) step();
    rdone[0] = 1'b1;
    rres[0]  = 32'h0000_1234;
    step();
    rdone[0] = 1'b0;
    valid[0] = '0;
    chk("tmo_race_done", done[0], 7'b0000100);
    chk("tmo_race_flag", tmo[0], 0);
    chk("tmo_race_result", result[0], 32'h0000_1234);
    step();
`endif

    do_reset();
    run_random(0, 200);
    run_random(1, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
